// File: rtl/rpn_bcd_stack_p_if.sv
// Keypad-in / display-out bundle for the RPN BCD stack core.
// Latency: none, wires only.
// Backpressure: none; keys arriving while the core is busy are dropped by the core.
interface rpn_bcd_stack_p_if #(
  parameter int NDIG = 4,
  parameter int SP_W = 4
);
  logic [4:0]        key_code;
  logic              key_strobe;
  logic [4*NDIG-1:0] disp_bcd;
  logic [NDIG-1:0]   disp_blank;
  logic              disp_dot;
  logic [SP_W-1:0]   sp;
  logic              busy;
  logic              error;

  // Keypad scanner / test side
  modport master (
    output key_code, key_strobe,
    input  disp_bcd, disp_blank, disp_dot, sp, busy, error
  );

  // Calculator core side
  modport slave (
    input  key_code, key_strobe,
    output disp_bcd, disp_blank, disp_dot, sp, busy, error
  );
endinterface

// File: rtl/rpn_bcd_stack_p.sv
// RPN calculator core: DEPTH-entry stack of NDIG-digit BCD numbers with digit-serial add/sub.
// Latency: key edge -> effect 2 cycles; PLUS/MINUS NDIG+3 cycles; CLEAR DEPTH+2 cycles; display +1.
// Backpressure: none; key edges seen outside IDLE are dropped, busy flags an arithmetic/clear op.
module rpn_bcd_stack_p #(
  parameter int NDIG  = 4,
  parameter int DEPTH = 16,
  parameter int SP_W  = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  rpn_bcd_stack_p_if.slave       io
);

  localparam int W     = 4*NDIG;
  localparam int CNT_W = $clog2(NDIG) + 1;
  localparam logic [SP_W-1:0] SP_MAX = SP_W'(DEPTH-1);

  localparam logic [4:0] K_PLUS  = 5'h10;
  localparam logic [4:0] K_MINUS = 5'h11;
  localparam logic [4:0] K_BACKS = 5'h12;
  localparam logic [4:0] K_ENTER = 5'h13;
  localparam logic [4:0] K_UP    = 5'h14;
  localparam logic [4:0] K_DOWN  = 5'h15;
  localparam logic [4:0] K_SWAP  = 5'h17;
  localparam logic [4:0] K_DROP  = 5'h18;
  localparam logic [4:0] K_CLEAR = 5'h19;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DECODE = 3'd1,
    S_ADD    = 3'd2,
    S_SUB    = 3'd3,
    S_WRITE  = 3'd4,
    S_CLR    = 3'd5
  } state_t;

  state_t            state;
  logic [W-1:0]      stk [DEPTH];
  logic [SP_W-1:0]   sp_r;
  logic [SP_W-1:0]   disp_p;
  logic [SP_W-1:0]   clr_idx;
  logic [4:0]        key_q;
  logic              strobe_q;
  logic              error_r;
  logic              busy_r;

  // Digit-serial datapath: operands shift right, result fills from the top
  logic [W-1:0]      op_a;
  logic [W-1:0]      op_b;
  logic [W-1:0]      res;
  logic              cy;
  logic [CNT_W-1:0]  dig_cnt;

  logic [W-1:0]      disp_bcd_r;
  logic [NDIG-1:0]   disp_blank_r;
  logic              disp_dot_r;

  // Combinational views of the stack around the pointer
  logic [W-1:0]      top_e;
  logic [W-1:0]      prev_e;
  logic [W-1:0]      prev2_e;
  logic [SP_W-1:0]   sp_m1;
  logic [SP_W-1:0]   sp_m2;
  logic [SP_W-1:0]   sp_p1;
  logic              key_edge;
  logic              key_is_digit;

  logic [4:0]        sum5;
  logic [4:0]        diff5;
  logic [3:0]        add_d;
  logic [3:0]        sub_d;
  logic              add_c;
  logic              sub_c;

  logic [W-1:0]      disp_e;
  logic [NDIG-1:0]   blank_c;

  // Stack neighbourhood and key classification
  always_comb begin
    sp_m1        = sp_r - 1'b1;
    sp_m2        = sp_r - SP_W'(2);
    sp_p1        = sp_r + 1'b1;
    top_e        = stk[sp_r];
    prev_e       = stk[sp_m1];
    prev2_e      = stk[sp_m2];
    key_edge     = io.key_strobe & ~strobe_q;
    key_is_digit = (key_q[4] == 1'b0) && (key_q[3:0] <= 4'd9);
  end

  // One BCD digit of add and subtract; only the one matching the state is used
  always_comb begin
    sum5  = {1'b0, op_a[3:0]} + {1'b0, op_b[3:0]} + {4'd0, cy};
    diff5 = {1'b0, op_a[3:0]} - {1'b0, op_b[3:0]} - {4'd0, cy};
    add_d = sum5[3:0];
    add_c = 1'b0;
    if (sum5 > 5'd9) begin
      add_d = sum5[3:0] + 4'd6;
      add_c = 1'b1;
    end
    sub_d = diff5[3:0];
    sub_c = 1'b0;
    if (diff5[4]) begin
      sub_d = diff5[3:0] + 4'd10;
      sub_c = 1'b1;
    end
  end

  // Leading-zero blanking of the browsed entry; digit 0 is always shown
  always_comb begin
    disp_e     = stk[disp_p];
    blank_c    = '0;
    for (int i = 1; i < NDIG; i++) begin
      blank_c[i] = ((disp_e >> (4*i)) == '0);
    end
  end

  // Control FSM, stack storage and registered display outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      for (int i = 0; i < DEPTH; i++) stk[i] <= '0;
      sp_r         <= '0;
      disp_p       <= '0;
      clr_idx      <= '0;
      key_q        <= '0;
      // Capture the live strobe so a key held through reset is not seen as an edge
      strobe_q     <= io.key_strobe;
      error_r      <= 1'b0;
      busy_r       <= 1'b0;
      op_a         <= '0;
      op_b         <= '0;
      res          <= '0;
      cy           <= 1'b0;
      dig_cnt      <= '0;
      disp_bcd_r   <= '0;
      disp_blank_r <= {{(NDIG-1){1'b1}}, 1'b0};
      disp_dot_r   <= 1'b0;
    end else begin
      strobe_q <= io.key_strobe;

      case (state)
        S_IDLE: begin
          if (key_edge) begin
            key_q <= io.key_code;
            state <= S_DECODE;
          end
        end

        S_DECODE: begin
          error_r <= 1'b0;
          state   <= S_IDLE;
          if (key_is_digit) begin
            if (top_e[W-1:W-4] == 4'd0) stk[sp_r] <= {top_e[W-5:0], key_q[3:0]};
            disp_p <= sp_r;
          end else begin
            case (key_q)
              K_BACKS: begin
                if (top_e != '0) begin
                  stk[sp_r] <= top_e >> 4;
                  disp_p    <= sp_r;
                end else if (sp_r != '0) begin
                  sp_r   <= sp_m1;
                  disp_p <= sp_m1;
                end else begin
                  disp_p <= sp_r;
                end
              end
              K_ENTER: begin
                if (top_e != '0 && sp_r == SP_MAX) begin
                  error_r <= 1'b1;
                  disp_p  <= sp_r;
                end else if (top_e != '0) begin
                  stk[sp_p1] <= '0;
                  sp_r       <= sp_p1;
                  disp_p     <= sp_p1;
                end else begin
                  disp_p <= sp_r;
                end
              end
              K_UP:   if (disp_p != '0) disp_p <= disp_p - 1'b1;
              K_DOWN: if (disp_p < sp_r)  disp_p <= disp_p + 1'b1;
              K_SWAP: begin
                if (sp_r != '0) begin
                  stk[sp_r] <= prev_e;
                  stk[sp_m1] <= top_e;
                end
              end
              K_DROP: begin
                stk[sp_r] <= '0;
                if (sp_r != '0) begin
                  sp_r   <= sp_m1;
                  disp_p <= sp_m1;
                end
              end
              K_CLEAR: begin
                sp_r    <= '0;
                disp_p  <= '0;
                clr_idx <= '0;
                busy_r  <= 1'b1;
                state   <= S_CLR;
              end
              K_PLUS, K_MINUS: begin
                if (sp_r != '0) begin
                  if (top_e != '0 || sp_r >= SP_W'(2)) begin
                    // A zero on top with two entries below is popped before the op
                    if (top_e != '0) begin
                      op_a <= prev_e;
                      op_b <= top_e;
                    end else begin
                      sp_r <= sp_m1;
                      op_a <= prev2_e;
                      op_b <= prev_e;
                    end
                    res     <= '0;
                    cy      <= 1'b0;
                    dig_cnt <= '0;
                    busy_r  <= 1'b1;
                    state   <= (key_q == K_MINUS) ? S_SUB : S_ADD;
                  end else begin
                    sp_r   <= '0;
                    disp_p <= '0;
                  end
                end
              end
              default: ;
            endcase
          end
        end

        S_ADD, S_SUB: begin
          res  <= {(state == S_SUB) ? sub_d : add_d, res[W-1:4]};
          cy   <= (state == S_SUB) ? sub_c : add_c;
          op_a <= op_a >> 4;
          op_b <= op_b >> 4;
          if (dig_cnt == CNT_W'(NDIG-1)) begin
            busy_r <= 1'b0;
            state  <= S_WRITE;
          end else begin
            dig_cnt <= dig_cnt + 1'b1;
          end
        end

        S_WRITE: begin
          // A leftover carry/borrow means overflow or negative result: leave the stack alone
          if (cy) begin
            error_r <= 1'b1;
          end else begin
            stk[sp_m1] <= res;
            stk[sp_r]  <= '0;
            sp_r       <= sp_m1;
            disp_p     <= sp_m1;
          end
          state <= S_IDLE;
        end

        S_CLR: begin
          stk[clr_idx] <= '0;
          clr_idx      <= clr_idx + 1'b1;
          if (clr_idx == SP_MAX) begin
            busy_r <= 1'b0;
            state  <= S_IDLE;
          end
        end

        default: begin
          busy_r <= 1'b0;
          state  <= S_IDLE;
        end
      endcase

      disp_bcd_r   <= error_r ? {W{1'b1}} : disp_e;
      disp_blank_r <= error_r ? '0 : blank_c;
      disp_dot_r   <= (disp_p != sp_r);
    end
  end

  assign io.disp_bcd   = disp_bcd_r;
  assign io.disp_blank = disp_blank_r;
  assign io.disp_dot   = disp_dot_r;
  assign io.sp         = sp_r;
  assign io.busy       = busy_r;
  assign io.error      = error_r;

endmodule
